// File: rtl/mac_pkg.sv
// mac_pkg: shared defaults, beat counter width and FSM state encodings
// for the mac_accum dot-product accumulator.
package mac_pkg;

  // Default operand and accumulator widths.
  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 20;

  // Beat counter width and its saturation value.
  localparam int               CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Frame-level FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_DRAIN = 2'b10,
    ST_HOLD  = 2'b11
  } mac_state_t;

  // Beat count increment that sticks at CNT_MAX instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// mac_sat_add: stage-2 adder of the MAC pipeline. Sign-extends the
// registered product to the accumulator width and adds it.
// Build option MAC_SATURATE_EN: when defined the sum clamps to the most
// positive / most negative accumulator value and 'clamped' flags it;
// otherwise the sum wraps and 'clamped' is held at 0.
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int PROD_W = 2 * DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [PROD_W-1:0] prod,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     clamped
);

  logic signed [ACC_W-1:0] prod_ext;

  assign prod_ext = ACC_W'(prod);

`ifdef MAC_SATURATE_EN

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W:0] sum_wide;

  assign sum_wide = (ACC_W+1)'(acc) + (ACC_W+1)'(prod_ext);

  // Clamp when the extra sign bit disagrees with the result sign bit.
  always_comb begin
    sum     = sum_wide[ACC_W-1:0];
    clamped = 1'b0;
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      clamped = 1'b1;
      sum     = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

`else

  assign sum     = acc + prod_ext;
  assign clamped = 1'b0;

`endif

endmodule

// File: rtl/mac_accum.sv
// mac_accum: two-stage signed multiply-accumulate with a frame FSM
// (IDLE -> ACCUM -> DRAIN -> HOLD) and a valid/ready result handshake.
// Build option MAC_SATURATE_EN selects a clamping accumulator with a
// per-frame overflow flag (see mac_sat_add); without it the sum wraps
// and overflow_o stays 0.
module mac_accum
  import mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     mac_en_i,
  input  logic                     mac_valid_i,
  input  logic signed [DATA_W-1:0] w_data_i,
  input  logic signed [DATA_W-1:0] x_data_i,
  input  logic                     done_i,
  output logic signed [ACC_W-1:0]  result_o,
  output logic [CNT_W-1:0]         beat_cnt_o,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic                     busy_o,
  output logic                     overflow_o,
  output logic                     err_o
);

  localparam int PROD_W = 2 * DATA_W;

  mac_state_t state_q, state_d;
  logic       drain_cnt_q;

  logic beat;
  logic accepting;
  logic beat_ok;
  logic enter_hold;
  logic release_hold;
  logic protocol_err;

  logic signed [PROD_W-1:0] prod_q;
  logic                     prod_vld_q;

  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_sum;
  logic                     acc_clamped;
  logic [CNT_W-1:0]         cnt_q;
  logic                     ovf_frame_q;

  assign beat         = mac_en_i & mac_valid_i;
  assign accepting    = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
  assign beat_ok      = beat & accepting;
  assign enter_hold   = (state_q == ST_DRAIN) && drain_cnt_q;
  assign release_hold = (state_q == ST_HOLD) && result_valid_o && result_ready_i;
  assign protocol_err = (beat & ~accepting)
                      | (done_i & ~accepting)
                      | (beat_ok & (cnt_q == CNT_MAX));

  assign busy_o = (state_q != ST_IDLE);

  // State register plus the two-cycle DRAIN timer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= (state_q == ST_DRAIN) ? ~drain_cnt_q : 1'b0;
    end
  end

  // Next-state logic; done_i wins over a coincident beat in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (done_i) begin
          state_d = ST_DRAIN;
        end else if (beat) begin
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (done_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (release_hold) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Stage 1: register the full-width product of each accepted beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
    end else if (release_hold) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
    end else begin
      prod_vld_q <= beat_ok;
      if (beat_ok) begin
        prod_q <= PROD_W'(w_data_i) * PROD_W'(x_data_i);
      end
    end
  end

  mac_sat_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_sat_add (
    .acc     (acc_q),
    .prod    (prod_q),
    .sum     (acc_sum),
    .clamped (acc_clamped)
  );

  // Stage 2: fold the registered product into the running sum.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q       <= '0;
      ovf_frame_q <= 1'b0;
    end else if (release_hold) begin
      acc_q       <= '0;
      ovf_frame_q <= 1'b0;
    end else if (prod_vld_q) begin
      acc_q <= acc_sum;
      if (acc_clamped) begin
        ovf_frame_q <= 1'b1;
      end
    end
  end

  // Count accepted beats in the current frame, sticking at CNT_MAX.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (release_hold) begin
      cnt_q <= '0;
    end else if (beat_ok) begin
      cnt_q <= cnt_sat_inc(cnt_q);
    end
  end

  // Capture the frame result on HOLD entry and hold it until accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_o       <= '0;
      beat_cnt_o     <= '0;
      overflow_o     <= 1'b0;
      result_valid_o <= 1'b0;
    end else if (enter_hold) begin
      result_o       <= acc_q;
      beat_cnt_o     <= cnt_q;
      overflow_o     <= ovf_frame_q;
      result_valid_o <= 1'b1;
    end else if (release_hold) begin
      result_valid_o <= 1'b0;
    end
  end

  // Sticky protocol error flag; only reset clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (protocol_err) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mac_accum.sv
// tb_mac_accum: scoreboard bench for mac_accum. Two instances share all
// inputs: the default ACC_W=20 build and an ACC_W=16 build that exercises
// accumulator overflow. Expected frames are pushed when done_i is driven
// and popped when result_valid_o rises.
module tb_mac_accum;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               mac_en_i;
  logic               mac_valid_i;
  logic signed [7:0]  w_data_i;
  logic signed [7:0]  x_data_i;
  logic               done_i;
  logic               result_ready_i;

  logic signed [19:0] result_o;
  logic [3:0]         beat_cnt_o;
  logic               result_valid_o;
  logic               busy_o;
  logic               overflow_o;
  logic               err_o;

  logic signed [15:0] result16;
  logic [3:0]         beat_cnt16;
  logic               valid16;
  logic               busy16;
  logic               ovf16;
  logic               err16;

  always #5 clk_i = ~clk_i;

  mac_accum #(.DATA_W(8), .ACC_W(20)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .mac_en_i       (mac_en_i),
    .mac_valid_i    (mac_valid_i),
    .w_data_i       (w_data_i),
    .x_data_i       (x_data_i),
    .done_i         (done_i),
    .result_o       (result_o),
    .beat_cnt_o     (beat_cnt_o),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .busy_o         (busy_o),
    .overflow_o     (overflow_o),
    .err_o          (err_o)
  );

  mac_accum #(.DATA_W(8), .ACC_W(16)) dut16 (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .mac_en_i       (mac_en_i),
    .mac_valid_i    (mac_valid_i),
    .w_data_i       (w_data_i),
    .x_data_i       (x_data_i),
    .done_i         (done_i),
    .result_o       (result16),
    .beat_cnt_o     (beat_cnt16),
    .result_valid_o (valid16),
    .result_ready_i (result_ready_i),
    .busy_o         (busy16),
    .overflow_o     (ovf16),
    .err_o          (err16)
  );

  typedef struct {
    longint r20;
    longint r16;
    int     cnt;
    bit     o20;
    bit     o16;
  } exp_t;

  exp_t   sb[$];
  int     n_cmp = 0;
  int     n_err = 0;

  longint m_sum20;
  longint m_sum16;
  int     m_cnt;
  bit     m_o20;
  bit     m_o16;
  bit     m_open;
  bit     m_err;

  // Reference add at a given accumulator width: clamp or wrap.
  function automatic longint addWidth(input longint a, input longint b,
                                      input int width, output bit clamp);
    longint hi;
    longint lo;
    longint s;
    hi    = (longint'(1) <<< (width - 1)) - 1;
    lo    = -(longint'(1) <<< (width - 1));
    s     = a + b;
    clamp = 1'b0;
`ifdef MAC_SATURATE_EN
    if (s > hi) begin
      s     = hi;
      clamp = 1'b1;
    end else if (s < lo) begin
      s     = lo;
      clamp = 1'b1;
    end
`else
    if (s > hi) begin
      s = s - (longint'(1) <<< width);
    end else if (s < lo) begin
      s = s + (longint'(1) <<< width);
    end
`endif
    return s;
  endfunction

  task automatic checkOutput(input string tag, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic clearFrame();
    m_sum20 = 0;
    m_sum16 = 0;
    m_cnt   = 0;
    m_o20   = 1'b0;
    m_o16   = 1'b0;
    m_open  = 1'b1;
  endtask

  task automatic modelReset();
    clearFrame();
    m_err = 1'b0;
    sb.delete();
  endtask

  task automatic idleInputs();
    mac_en_i    = 1'b0;
    mac_valid_i = 1'b0;
    w_data_i    = '0;
    x_data_i    = '0;
    done_i      = 1'b0;
  endtask

  // Drive one cycle of inputs and advance the reference model.
  task automatic applyStimulus(input bit en, input bit vld, input int w,
                               input int x, input bit done);
    longint p;
    bit     c;
    exp_t   e;
    @(negedge clk_i);
    mac_en_i    = en;
    mac_valid_i = vld;
    w_data_i    = 8'(w);
    x_data_i    = 8'(x);
    done_i      = done;
    if (en && vld) begin
      if (m_open) begin
        p       = longint'(w) * longint'(x);
        m_sum20 = addWidth(m_sum20, p, 20, c);
        m_o20   = m_o20 | c;
        m_sum16 = addWidth(m_sum16, p, 16, c);
        m_o16   = m_o16 | c;
        if (m_cnt == 15) begin
          m_err = 1'b1;
        end else begin
          m_cnt++;
        end
      end else begin
        m_err = 1'b1;
      end
    end
    if (done) begin
      if (m_open) begin
        e.r20  = m_sum20;
        e.r16  = m_sum16;
        e.cnt  = m_cnt;
        e.o20  = m_o20;
        e.o16  = m_o16;
        sb.push_back(e);
        m_open = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  // Complete the handshake and confirm the return to IDLE.
  task automatic acceptResult();
    @(negedge clk_i);
    idleInputs();
    result_ready_i = 1'b1;
    @(negedge clk_i);
    result_ready_i = 1'b0;
    checkOutput("busy_after_accept", busy_o, 0);
    checkOutput("valid_after_accept", result_valid_o, 0);
    checkOutput("busy16_after_accept", busy16, 0);
    clearFrame();
  endtask

  // Wait (bounded) for result_valid_o, check latency, pop and compare.
  task automatic waitResult(input bit accept);
    int   lat;
    exp_t e;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_i);
      idleInputs();
      if (result_valid_o) begin
        lat = k;
        break;
      end
    end
    checkOutput("latency", lat, 3);
    if (sb.size() == 0) begin
      checkOutput("sb_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      checkOutput("result20", result_o, e.r20);
      checkOutput("cnt20", beat_cnt_o, e.cnt);
      checkOutput("ovf20", overflow_o, e.o20);
      checkOutput("valid16", valid16, 1);
      checkOutput("result16", result16, e.r16);
      checkOutput("cnt16", beat_cnt16, e.cnt);
      checkOutput("ovf16", ovf16, e.o16);
      checkOutput("busy_hold", busy_o, 1);
    end
    checkOutput("err", err_o, m_err);
    checkOutput("err16", err16, m_err);
    if (accept) begin
      acceptResult();
    end
  endtask

  // Safety net so a stuck design cannot hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    longint held;
    rst_i          = 1'b1;
    result_ready_i = 1'b0;
    idleInputs();
    modelReset();
    repeat (2) @(negedge clk_i);
    checkOutput("rst_result", result_o, 0);
    checkOutput("rst_cnt", beat_cnt_o, 0);
    checkOutput("rst_valid", result_valid_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_ovf", overflow_o, 0);
    checkOutput("rst_err", err_o, 0);
    checkOutput("rst_ovf16", ovf16, 0);
    rst_i = 1'b0;

    $display("[TB] ramp weights 1..8 times 1");
    for (int w = 1; w <= 8; w++) applyStimulus(1, 1, w, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    waitResult(1);

    $display("[TB] negative products with beat on done");
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, -3, 5, 0);
    applyStimulus(1, 1, 2, 2, 1);
    waitResult(1);

    $display("[TB] accumulator overflow at 16 bits");
    for (int i = 0; i < 2; i++) applyStimulus(1, 1, -128, -128, 0);
    applyStimulus(0, 0, 0, 0, 1);
    waitResult(1);

    $display("[TB] empty frame");
    applyStimulus(0, 0, 0, 0, 1);
    waitResult(1);

    $display("[TB] beat count saturation");
    for (int i = 0; i < 17; i++) applyStimulus(1, 1, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    waitResult(1);

    $display("[TB] back-pressure in HOLD with dropped beats");
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 7, 3, 0);
    applyStimulus(0, 0, 0, 0, 1);
    held = m_sum20;
    waitResult(0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 9, 9, 0);
      checkOutput("hold_result", result_o, held);
      checkOutput("hold_valid", result_valid_o, 1);
    end
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("hold_err", err_o, m_err);
    acceptResult();

    $display("[TB] reset in the middle of a frame");
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 5, 5, 0);
    @(negedge clk_i);
    idleInputs();
    rst_i = 1'b1;
    modelReset();
    #1;
    checkOutput("midrst_err", err_o, 0);
    checkOutput("midrst_busy", busy_o, 0);
    checkOutput("midrst_valid", result_valid_o, 0);
    checkOutput("midrst_result", result_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 2; i++) applyStimulus(1, 1, 4, 4, 0);
    applyStimulus(0, 0, 0, 0, 1);
    waitResult(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mac_accum.md
MAC_ACCUM -- requirements
Module: mac_accum

Interface
REQ-001 Parameter DATA_W, default 8: signed width of weight and input operands.
REQ-002 Parameter ACC_W, default 20: signed accumulator and result width; legal range 2*DATA_W to 32.
REQ-003 Port clk_i, input, 1: single clock; all logic on its rising edge.
REQ-004 Port rst_i, input, 1: asynchronous, active-high reset.
REQ-005 Port mac_en_i, input, 1: accumulation enable from the controller.
REQ-006 Port mac_valid_i, input, 1: w_data_i and x_data_i are valid this cycle.
REQ-007 Port w_data_i, input, DATA_W: signed weight operand.
REQ-008 Port x_data_i, input, DATA_W: signed input operand.
REQ-009 Port done_i, input, 1: single-cycle end-of-frame pulse from the controller.
REQ-010 Port result_o, output, ACC_W: signed dot-product result.
REQ-011 Port beat_cnt_o, output, 4: number of beats accumulated into result_o, saturating at 15.
REQ-012 Port result_valid_o, output, 1: result_o and beat_cnt_o are valid.
REQ-013 Port result_ready_i, input, 1: consumer accepts the result.
REQ-014 Port busy_o, output, 1: high in any state other than IDLE.
REQ-015 Port overflow_o, output, 1: accumulator overflowed during the frame now held in result_o.
REQ-016 Port err_o, output, 1: sticky protocol error.

Function
REQ-017 A beat is a cycle with mac_en_i=1 and mac_valid_i=1; a beat in IDLE moves the state to ACCUM.
REQ-018 Stage 1: the full-width product w_data_i*x_data_i (2*DATA_W, signed) is registered on the beat cycle.
REQ-019 Stage 2: the registered product is sign-extended to ACC_W and added to the accumulator one cycle later.
REQ-020 States are IDLE, ACCUM, DRAIN and HOLD.
REQ-021 IDLE->ACCUM on a beat.
REQ-022 IDLE or ACCUM->DRAIN on done_i; a beat coincident with done_i is included in the frame.
REQ-023 DRAIN lasts 2 cycles so the pipeline empties, then the state moves to HOLD.
REQ-024 On entry to HOLD, result_o and beat_cnt_o are registered and result_valid_o is set to 1.
REQ-025 HOLD->IDLE on the cycle result_valid_o=1 and result_ready_i=1; the accumulator, beat count and pipeline clear in that same cycle.
REQ-026 result_o, beat_cnt_o and overflow_o stay stable while result_valid_o=1 and result_ready_i=0.
REQ-027 Beats arriving in DRAIN or HOLD are discarded and set err_o.
REQ-028 A done_i arriving in DRAIN or HOLD is ignored and sets err_o.
REQ-029 done_i with no prior beats produces result_o=0, beat_cnt_o=0 after the DRAIN latency.
REQ-030 A beat arriving when beat_cnt is already 15 is still accumulated, beat_cnt holds at 15, and err_o is set.
REQ-031 Latency: result_valid_o rises 3 cycles after the done_i cycle.
REQ-032 err_o clears only on reset.

Reset
REQ-033 While rst_i=1: state is IDLE, and the accumulator, pipeline, result_o, beat_cnt_o, result_valid_o, busy_o, overflow_o and err_o are all 0.
REQ-034 Reset mid-frame discards the partial sum; the first beat after reset starts a new frame from 0.

Configuration
REQ-035 With MAC_SATURATE_EN defined, the stage-2 add clamps to +(2^(ACC_W-1)-1) or -2^(ACC_W-1), and any clamp sets a per-frame overflow flag that is copied to overflow_o at HOLD entry.
REQ-036 Without MAC_SATURATE_EN, the add wraps modulo 2^ACC_W and overflow_o is tied to 0.

Structure
REQ-037 Package mac_pkg holds the DATA_W and ACC_W defaults, the beat counter width, and the state encodings (IDLE=2'b00, ACCUM=2'b01, DRAIN=2'b10, HOLD=2'b11).
REQ-038 The stage-2 adder, including the saturation logic and overflow detect, is a sub-module mac_sat_add.

Verification
REQ-039 8 beats w=1..8, x=1, then done_i -> 3 cycles later result_o=36, beat_cnt_o=8, result_valid_o=1.
REQ-040 8 beats w=-3, x=5 -> result_o=-120; a beat coincident with done_i (w=2, x=2) is included, giving result_o=-116, beat_cnt_o=9.
REQ-041 ACC_W=16, 2 beats w=-128, x=-128 -> with MAC_SATURATE_EN, result_o=32767 and overflow_o=1; without it, result_o=-32768 and overflow_o=0.
REQ-042 result_ready_i held low for 5 cycles in HOLD with beats applied -> result_o unchanged, beats dropped, err_o=1; on ready=1, IDLE the next cycle.
REQ-043 rst_i pulsed after 3 beats, then a 2-beat frame w=4, x=4 -> result_o=32, beat_cnt_o=2, err_o=0.
REQ-044 done_i with no beats -> result_o=0, beat_cnt_o=0, result_valid_o=1 after 3 cycles.
